// File: rtl/dev_bus_arbiter.sv
// Two-master (CPU=m0, DMA=m1) round-robin arbiter and address decoder for a
// seven-target device bus.
// Latency: grant at the req edge; ack two cycles later (ready at once) or one cycle later on decode fault.
// Backpressure: masters hold req until ack; the target stalls via dev_ready, bounded by TIMEOUT cycles.
module dev_bus_arbiter #(
    parameter int TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m0_req,
    input  logic [31:0] m0_addr,
    input  logic        m0_we,
    input  logic [1:0]  m0_size,
    input  logic [31:0] m0_wdata,
    output logic        m0_ack,
    output logic        m0_err,
    output logic [31:0] m0_rdata,
    input  logic        m1_req,
    input  logic [31:0] m1_addr,
    input  logic        m1_we,
    input  logic [1:0]  m1_size,
    input  logic [31:0] m1_wdata,
    output logic        m1_ack,
    output logic        m1_err,
    output logic [31:0] m1_rdata,
    output logic [6:0]  dev_sel,
    output logic [31:0] dev_addr,
    output logic        dev_we,
    output logic [1:0]  dev_size,
    output logic [31:0] dev_wdata,
    input  logic [31:0] dev_rdata,
    input  logic        dev_ready
);

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP, S_FAULT} state_t;

    // Counter only needs to reach TIMEOUT-1: the TIMEOUT-th cycle is the compare cycle.
    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

    state_t            state_q;
    logic              last_grant_q;
    logic              gnt_q;
    logic [CW-1:0]     cnt_q;
    logic [6:0]        dev_sel_q;
    logic [31:0]       dev_addr_q;
    logic              dev_we_q;
    logic [1:0]        dev_size_q;
    logic [31:0]       dev_wdata_q;
    logic [1:0]        ack_q;
    logic [1:0]        err_q;
    logic [1:0][31:0]  rdata_q;

    logic              gnt_vld_d;
    logic              gnt_sel_d;
    logic [31:0]       req_addr_d;
    logic              req_we_d;
    logic [1:0]        req_size_d;
    logic [31:0]       req_wdata_d;
    logic [6:0]        sel_oh_d;
    logic              fault_d;

    // Round-robin pick: a tie goes to the master that was not granted last.
    always_comb begin
        gnt_vld_d   = m0_req | m1_req;
        gnt_sel_d   = (m0_req & m1_req) ? ~last_grant_q : m1_req;
        req_addr_d  = gnt_sel_d ? m1_addr  : m0_addr;
        req_we_d    = gnt_sel_d ? m1_we    : m0_we;
        req_size_d  = gnt_sel_d ? m1_size  : m0_size;
        req_wdata_d = gnt_sel_d ? m1_wdata : m0_wdata;
    end

    // Address decode of the winning request plus every fault it can raise at grant.
    always_comb begin
        sel_oh_d = 7'h00;
        if (req_addr_d <= 32'h0000_2FFF)
            sel_oh_d = 7'h01;
        else if (req_addr_d >= 32'h0000_7F00 && req_addr_d <= 32'h0000_7F0B)
            sel_oh_d = 7'h02;
        else if (req_addr_d >= 32'h0000_7F10 && req_addr_d <= 32'h0000_7F2B)
            sel_oh_d = 7'h04;
        else if (req_addr_d >= 32'h0000_7F2C && req_addr_d <= 32'h0000_7F33)
            sel_oh_d = 7'h08;
        else if (req_addr_d >= 32'h0000_7F34 && req_addr_d <= 32'h0000_7F37)
            sel_oh_d = 7'h10;
        else if (req_addr_d >= 32'h0000_7F38 && req_addr_d <= 32'h0000_7F3F)
            sel_oh_d = 7'h20;
        else if (req_addr_d >= 32'h0000_7F40 && req_addr_d <= 32'h0000_7F43)
            sel_oh_d = 7'h40;

        fault_d = (sel_oh_d == 7'h00)
                | (req_size_d == 2'b11)
                | (req_size_d == 2'b10 && req_addr_d[1:0] != 2'b00)
                | (req_size_d == 2'b01 && req_addr_d[0])
                | (sel_oh_d[1] && req_size_d != 2'b10)
                | (req_we_d && (req_addr_d == 32'h0000_7F08 || req_addr_d == 32'h0000_7F18));
    end

    // Bus FSM with all outputs registered; ack/err default low so they pulse for one cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            last_grant_q <= 1'b1;
            gnt_q        <= 1'b0;
            cnt_q        <= '0;
            dev_sel_q    <= 7'h00;
            dev_addr_q   <= 32'h0;
            dev_we_q     <= 1'b0;
            dev_size_q   <= 2'b00;
            dev_wdata_q  <= 32'h0;
            ack_q        <= 2'b00;
            err_q        <= 2'b00;
            rdata_q      <= '0;
        end else begin
            ack_q <= 2'b00;
            err_q <= 2'b00;
            case (state_q)
                S_IDLE: begin
                    if (gnt_vld_d) begin
                        gnt_q        <= gnt_sel_d;
                        last_grant_q <= gnt_sel_d;
                        dev_addr_q   <= req_addr_d;
                        dev_we_q     <= req_we_d;
                        dev_size_q   <= req_size_d;
                        dev_wdata_q  <= req_wdata_d;
                        cnt_q        <= '0;
                        if (fault_d) begin
                            state_q            <= S_FAULT;
                            ack_q[gnt_sel_d]   <= 1'b1;
                            err_q[gnt_sel_d]   <= 1'b1;
                            rdata_q[gnt_sel_d] <= 32'h0;
                        end else begin
                            state_q   <= S_ACCESS;
                            dev_sel_q <= sel_oh_d;
                        end
                    end
                end
                S_ACCESS: begin
                    if (dev_ready) begin
                        state_q        <= S_RESP;
                        dev_sel_q      <= 7'h00;
                        ack_q[gnt_q]   <= 1'b1;
                        rdata_q[gnt_q] <= dev_we_q ? 32'h0 : dev_rdata;
                    end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                        state_q        <= S_FAULT;
                        dev_sel_q      <= 7'h00;
                        ack_q[gnt_q]   <= 1'b1;
                        err_q[gnt_q]   <= 1'b1;
                        rdata_q[gnt_q] <= 32'h0;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                S_RESP:  state_q <= S_IDLE;
                S_FAULT: state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign m0_ack    = ack_q[0];
    assign m1_ack    = ack_q[1];
    assign m0_err    = err_q[0];
    assign m1_err    = err_q[1];
    assign m0_rdata  = rdata_q[0];
    assign m1_rdata  = rdata_q[1];
    assign dev_sel   = dev_sel_q;
    assign dev_addr  = dev_addr_q;
    assign dev_we    = dev_we_q;
    assign dev_size  = dev_size_q;
    assign dev_wdata = dev_wdata_q;

endmodule

// File: tb/tb_dev_bus_arbiter.sv
// Bench for dev_bus_arbiter: table of single transactions, tie/round-robin pairs, mid-access reset.
// Expected acks are queued when a request is driven and popped by the negedge monitor.
// The target model raises dev_ready on a programmed ACCESS cycle (0 = never).
module tb_dev_bus_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic [1:0]  m0_size, m1_size;
    logic        m0_ack, m0_err, m1_ack, m1_err;
    logic [31:0] m0_rdata, m1_rdata;
    logic [6:0]  dev_sel;
    logic [31:0] dev_addr, dev_wdata, dev_rdata;
    logic        dev_we, dev_ready;
    logic [1:0]  dev_size;

    always #5 clk = ~clk;

    dev_bus_arbiter #(.TIMEOUT(15)) dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_addr(m0_addr), .m0_we(m0_we), .m0_size(m0_size), .m0_wdata(m0_wdata),
        .m0_ack(m0_ack), .m0_err(m0_err), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_addr(m1_addr), .m1_we(m1_we), .m1_size(m1_size), .m1_wdata(m1_wdata),
        .m1_ack(m1_ack), .m1_err(m1_err), .m1_rdata(m1_rdata),
        .dev_sel(dev_sel), .dev_addr(dev_addr), .dev_we(dev_we), .dev_size(dev_size),
        .dev_wdata(dev_wdata), .dev_rdata(dev_rdata), .dev_ready(dev_ready)
    );

    typedef struct packed {
        logic        m;
        logic        err;
        logic [31:0] rd;
    } exp_t;

    typedef struct {
        bit          m;
        logic [31:0] addr;
        bit          we;
        logic [1:0]  size;
        logic [31:0] wdata;
        logic [31:0] rd_in;
        int          delay;
        bit          err;
        logic [6:0]  sel;
        logic [31:0] rd_exp;
        int          lat;
    } vec_t;

    int          checks = 0;
    int          errors = 0;
    exp_t        sbq[$];
    exp_t        mon_e;
    logic [31:0] mdl_rd [2];
    int          cur_delay = 0;
    int          access_cnt = 0;
    bit          sel_seen = 0;
    bit          chk_dev = 0;
    logic [6:0]  exp_sel_cur = 7'h00;
    logic [31:0] exp_addr_cur = 32'h0;
    logic [31:0] exp_wdata_cur = 32'h0;
    bit          exp_we_cur = 0;
    logic [1:0]  exp_size_cur = 2'b00;
    vec_t        vecs [19];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Scoreboard pop, rdata-hold model and target model, all on the falling edge.
    always @(negedge clk) begin
        if (!reset) begin
            sbq.delete();
            mdl_rd[0] = 32'h0;
            mdl_rd[1] = 32'h0;
            access_cnt = 0;
            dev_ready = 1'b0;
        end else begin
            if (m0_ack || m1_ack) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_ack", {30'b0, m1_ack, m0_ack}, 32'h0);
                end else begin
                    mon_e = sbq.pop_front();
                    chk("ack_master", {30'b0, m1_ack, m0_ack}, mon_e.m ? 32'h2 : 32'h1);
                    chk("ack_err", 32'(mon_e.m ? m1_err : m0_err), 32'(mon_e.err));
                    mdl_rd[mon_e.m] = mon_e.rd;
                end
            end
            if ((m0_err && !m0_ack) || (m1_err && !m1_ack))
                chk("err_without_ack", {30'b0, m1_err, m0_err}, {30'b0, m1_ack, m0_ack});
            chk("m0_rdata", m0_rdata, mdl_rd[0]);
            chk("m1_rdata", m1_rdata, mdl_rd[1]);
            if (dev_sel != 7'h00) begin
                sel_seen = 1;
                chk("dev_sel", 32'(dev_sel), 32'(exp_sel_cur));
                if (chk_dev) begin
                    chk("dev_addr", dev_addr, exp_addr_cur);
                    chk("dev_we", 32'(dev_we), 32'(exp_we_cur));
                    chk("dev_size", 32'(dev_size), 32'(exp_size_cur));
                    chk("dev_wdata", dev_wdata, exp_wdata_cur);
                end
                access_cnt++;
                dev_ready = (cur_delay != 0) && (access_cnt == cur_delay);
            end else begin
                access_cnt = 0;
                dev_ready = 1'b0;
            end
        end
    end

    task automatic drive_m(input bit m, input bit req, input logic [31:0] addr, input bit we,
                           input logic [1:0] size, input logic [31:0] wdata);
        if (m) begin
            m1_req = req; m1_addr = addr; m1_we = we; m1_size = size; m1_wdata = wdata;
        end else begin
            m0_req = req; m0_addr = addr; m0_we = we; m0_size = size; m0_wdata = wdata;
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_acks"}, {28'b0, m1_err, m1_ack, m0_err, m0_ack}, 32'h0);
        chk({tag, "_m0_rdata"}, m0_rdata, 32'h0);
        chk({tag, "_m1_rdata"}, m1_rdata, 32'h0);
        chk({tag, "_dev_sel"}, 32'(dev_sel), 32'h0);
        chk({tag, "_dev_addr"}, dev_addr, 32'h0);
        chk({tag, "_dev_wdata"}, dev_wdata, 32'h0);
        chk({tag, "_dev_we_size"}, {29'b0, dev_we, dev_size}, 32'h0);
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        m0_req = 1'b0;
        m1_req = 1'b0;
        repeat (2) @(negedge clk);
        #1 chk_zero("reset");
        #1 reset = 1'b1;
    endtask

    task automatic run_txn(input vec_t v, input int idx);
        int lat;
        bit got;
        @(negedge clk);
        cur_delay = v.delay;
        dev_rdata = v.rd_in;
        exp_sel_cur = v.sel;
        exp_addr_cur = v.addr;
        exp_we_cur = v.we;
        exp_size_cur = v.size;
        exp_wdata_cur = v.wdata;
        chk_dev = 1;
        sel_seen = 0;
        sbq.push_back('{v.m, v.err, v.rd_exp});
        drive_m(v.m, 1'b1, v.addr, v.we, v.size, v.wdata);
        lat = 0;
        got = 0;
        while (!got && lat < 100) begin
            @(negedge clk);
            lat++;
            got = v.m ? m1_ack : m0_ack;
        end
        if (v.m) m1_req = 1'b0; else m0_req = 1'b0;
        chk($sformatf("vec%0d_latency", idx), got ? lat : 0, v.lat);
        chk($sformatf("vec%0d_sel_pulse", idx), 32'(sel_seen), 32'(v.sel != 7'h00));
    endtask

    // Both masters request in the same cycle; 'first' is the master expected to win the tie.
    task automatic run_pair(input bit first, input int lat0_exp, input int lat1_exp, input string nm);
        exp_t e;
        int lat0, lat1, n;
        @(negedge clk);
        cur_delay = 1;
        dev_rdata = 32'h0BAD_BEEF;
        exp_sel_cur = 7'h01;
        chk_dev = 0;
        e.err = 1'b0;
        e.rd = 32'h0BAD_BEEF;
        e.m = first;
        sbq.push_back(e);
        e.m = ~first;
        sbq.push_back(e);
        drive_m(0, 1'b1, 32'h0000_0000, 1'b0, 2'b10, 32'h0);
        drive_m(1, 1'b1, 32'h0000_0004, 1'b0, 2'b10, 32'h0);
        lat0 = 0;
        lat1 = 0;
        n = 0;
        while ((lat0 == 0 || lat1 == 0) && n < 100) begin
            @(negedge clk);
            n++;
            if (m0_ack && lat0 == 0) begin lat0 = n; m0_req = 1'b0; end
            if (m1_ack && lat1 == 0) begin lat1 = n; m1_req = 1'b0; end
        end
        m0_req = 1'b0;
        m1_req = 1'b0;
        chk({nm, "_m0_latency"}, lat0, lat0_exp);
        chk({nm, "_m1_latency"}, lat1, lat1_exp);
    endtask

    initial begin
        vec_t v;
        m0_addr = 0; m0_we = 0; m0_size = 0; m0_wdata = 0;
        m1_addr = 0; m1_we = 0; m1_size = 0; m1_wdata = 0;
        dev_rdata = 0;
        dev_ready = 0;
        //          m   addr          we  size   wdata         rd_in         dly err sel    rd_exp        lat
        vecs[0]  = '{0, 32'h0000_0000, 0, 2'b10, 32'h0,        32'h1111_2222, 1, 0, 7'h01, 32'h1111_2222, 2};
        vecs[1]  = '{1, 32'h0000_0004, 1, 2'b10, 32'hA5A5_A5A5, 32'h9999_9999, 1, 0, 7'h01, 32'h0,        2};
        vecs[2]  = '{0, 32'h0000_7F08, 1, 2'b10, 32'h1,        32'h0,        1, 1, 7'h00, 32'h0,        1};
        vecs[3]  = '{1, 32'h0000_0003, 0, 2'b01, 32'h0,        32'h0,        1, 1, 7'h00, 32'h0,        1};
        vecs[4]  = '{1, 32'h0000_3000, 0, 2'b10, 32'h0,        32'h0,        1, 1, 7'h00, 32'h0,        1};
        vecs[5]  = '{0, 32'h0000_7F44, 0, 2'b00, 32'h0,        32'h0,        1, 1, 7'h00, 32'h0,        1};
        vecs[6]  = '{0, 32'h0000_7F10, 0, 2'b10, 32'h0,        32'hDEAD_BEEF, 0, 1, 7'h04, 32'h0,        16};
        vecs[7]  = '{0, 32'h0000_7F10, 0, 2'b10, 32'h0,        32'hCAFE_F00D, 15, 0, 7'h04, 32'hCAFE_F00D, 16};
        vecs[8]  = '{1, 32'h0000_7F00, 0, 2'b00, 32'h0,        32'h0,        1, 1, 7'h00, 32'h0,        1};
        vecs[9]  = '{0, 32'h0000_7F04, 0, 2'b10, 32'h0,        32'h0000_0777, 3, 0, 7'h02, 32'h0000_0777, 4};
        vecs[10] = '{1, 32'h0000_0000, 0, 2'b11, 32'h0,        32'h0,        1, 1, 7'h00, 32'h0,        1};
        vecs[11] = '{0, 32'h0000_7F2C, 0, 2'b01, 32'h0,        32'h0000_ABCD, 2, 0, 7'h08, 32'h0000_ABCD, 3};
        vecs[12] = '{1, 32'h0000_7F34, 1, 2'b00, 32'h0000_00FF, 32'h0000_1234, 1, 0, 7'h10, 32'h0,        2};
        vecs[13] = '{0, 32'h0000_7F38, 0, 2'b10, 32'h0,        32'h55AA_55AA, 1, 0, 7'h20, 32'h55AA_55AA, 2};
        vecs[14] = '{1, 32'h0000_7F43, 0, 2'b00, 32'h0,        32'h0000_0003, 1, 0, 7'h40, 32'h0000_0003, 2};
        vecs[15] = '{0, 32'h0000_2FFF, 0, 2'b00, 32'h0,        32'h0000_007E, 1, 0, 7'h01, 32'h0000_007E, 2};
        vecs[16] = '{1, 32'h0000_7F18, 1, 2'b10, 32'h0,        32'h0,        1, 1, 7'h00, 32'h0,        1};
        vecs[17] = '{0, 32'h0000_7F0C, 0, 2'b10, 32'h0,        32'h0,        1, 1, 7'h00, 32'h0,        1};
        vecs[18] = '{1, 32'h0000_7F08, 0, 2'b10, 32'h0,        32'h0000_0042, 1, 0, 7'h02, 32'h0000_0042, 2};

        apply_reset();

        // Tie straight out of reset: m0 first (ack 2), m1 next (ack 5).
        run_pair(1'b0, 2, 5, "tie_from_reset");

        for (int i = 0; i < 19; i++) run_txn(vecs[i], i);

        // After an m0 grant, a tie must go to m1.
        run_txn(vecs[0], 100);
        run_pair(1'b1, 5, 2, "tie_after_m0");

        // Reset while m0 is stalled in ACCESS and m1 is waiting.
        @(negedge clk);
        cur_delay = 0;
        exp_sel_cur = 7'h01;
        chk_dev = 0;
        sbq.push_back('{1'b0, 1'b0, 32'h0});
        drive_m(0, 1'b1, 32'h0000_0000, 1'b0, 2'b10, 32'h0);
        repeat (3) @(negedge clk);
        chk("midreset_in_access", 32'(dev_sel), 32'h01);
        drive_m(1, 1'b1, 32'h0000_0008, 1'b0, 2'b10, 32'h0);
        repeat (2) @(negedge clk);
        #2 reset = 1'b0;
        #1 chk_zero("midreset");
        m0_req = 1'b0;
        m1_req = 1'b0;
        repeat (2) @(negedge clk);
        #2 reset = 1'b1;
        v = '{1, 32'h0000_0008, 0, 2'b10, 32'h0, 32'h7777_0001, 1, 0, 7'h01, 32'h7777_0001, 2};
        run_txn(v, 200);

        repeat (3) @(negedge clk);
        chk("queue_drained", sbq.size(), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule
